time_bcd_converter: RTL and testbench
=====================================

# time_bcd_converter

Sequential, parametrised binary-seconds to BCD MM:SS converter for the parking-meter display path. It accepts a remaining-time value in seconds over a valid/ready handshake and converts it by iterative subtraction. It then presents registered minute, seconds-tens and seconds-ones digits to the seven-segment driver. Against the earlier combinational digit split, it adds:
- configurable input width;
- configurable minute-digit count;
- saturation with an overflow flag;
- optional leading-zero blanking.

## Interface
- SEC_W, 12: width of the binary seconds input.
- MIN_DIGITS, 2: number of BCD minute digits; maximum displayable time is (10^MIN_DIGITS − 1):59.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sec_count is valid.
- in_ready  out  1  converter can accept; high only in IDLE and low while rst is high.
- sec_count  in  SEC_W  binary remaining seconds.
- out_valid  out  1  one-cycle pulse when the digit outputs have been updated.
- min_digits  out  4*MIN_DIGITS  BCD minutes; the most significant digit is in the top nibble.
- sec_tens  out  4  BCD seconds tens, 0–5.
- sec_ones  out  4  BCD seconds ones, 0–9.
- overflow  out  1  the last result was saturated; held with the digits.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, capture rem ← sec_count, clear the working minutes, clear tens, go to MIN.
  - MIN: if rem ≥ 60, then rem ← rem − 60 and working minutes += 1 (BCD). Else go to TENS.
  - MIN saturation: if rem ≥ 60 and the working minutes are already all-9s:
    - set the working value to max:59;
    - set the overflow bit;
    - go directly to DONE.
  - TENS: if rem ≥ 10, then rem ← rem − 10 and tens += 1. Else ones ← rem[3:0] and go to DONE.
  - DONE: copy the working digits and the overflow bit into the output registers, pulse out_valid, return to IDLE.
- Output registers change only at the DONE edge. Between results, outputs hold their last value.
- rem is SEC_W bits wide. The comparison against 60 is performed at SEC_W bits. For SEC_W < 6, MIN always exits immediately.
- in_valid while in_ready=0 is ignored; it is neither queued nor flagged.
- Reset:
  - State returns to IDLE.
  - min_digits, sec_tens, sec_ones, overflow and out_valid reset to 0.
  - A conversion in progress is discarded, and no out_valid is produced for it.

## Timing
- The accept edge is E0, where in_valid && in_ready.
- Let M = minutes and T = seconds tens of the result.
- out_valid is high in the cycle following edge E0 + M + T + 3.
  - MIN takes M+1 cycles, TENS takes T+1, DONE takes 1.
- Saturated case: out_valid follows edge E0 + (10^MIN_DIGITS) + 2. TENS is skipped.
- in_ready is 1 in the same cycle that out_valid is 1, so back-to-back accepts are allowed.
- Worst-case unsaturated latency: 10^MIN_DIGITS − 1 + 5 + 3 cycles.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: during DONE, each leading minute digit equal to 0 is replaced by the blank code 4'hF, scanning from the most significant digit. Scanning stops at the first non-zero digit. The minutes ones digit is never blanked. Example: 5 min with MIN_DIGITS=2 shows min_digits = 8'hF5.
  - Not defined: plain BCD zeros.
- Reset values are unaffected by the macro: all zeros in both builds.

## Structure
- Shared package time_display_pkg holds:
  - SECS_PER_MIN = 60;
  - SECS_PER_TEN = 10;
  - BCD_BLANK = 4'hF;
  - the state enum (IDLE, MIN, TENS, DONE).
- Sub-module bcd_incr:
  - Parameter DIGITS.
  - Combinational DIGITS-digit BCD incrementer.
  - Output all_nines flag, used by MIN for saturation.
  - Reused by the meter's coin-add path.

## Test plan
- Reset, then sec_count=0 → out_valid 3 cycles after accept with min_digits=8'h00, sec_tens=0, sec_ones=0, overflow=0.
- sec_count=754 → 12:34 (min_digits=8'h12, sec_tens=3, sec_ones=4); out_valid 18 cycles after accept; in_ready low throughout.
- SEC_W=16, sec_count=5999 → 99:59 with overflow=0. Then sec_count=6000 → 99:59 with overflow=1, out_valid 102 cycles after accept.
- Reset mid-conversion:
  - Accept 754, assert rst for 1 cycle at cycle 5.
  - Required: no out_valid, outputs 0, in_ready high the cycle after rst falls.
- Back-to-back and ignored input:
  - Accept 61, hold in_valid with 9 while busy.
  - Required: that 9 is ignored while busy; 01:01 is reported. Then 9 is accepted on the out_valid cycle, giving 00:09.
- LEADING_ZERO_BLANK_EN defined: sec_count=59 → min_digits=8'hF0, sec_tens=5, sec_ones=9.

Source files
------------

// File: rtl/time_display_pkg.sv
// Shared constants and state type for the parking-meter time display path.
package time_display_pkg;

    localparam int         SECS_PER_MIN = 60;
    localparam int         SECS_PER_TEN = 10;
    localparam logic [3:0] BCD_BLANK    = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIN  = 2'd1,
        TENS = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/time_bcd_converter_bcd_incr.sv
// Combinational DIGITS-digit BCD incrementer with an all-nines flag.
// Shared with the coin-add path; wraps to all zeros when incremented from all nines.
module bcd_incr
    import time_display_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] i_val,
    output logic [4*DIGITS-1:0] o_val,
    output logic                o_all_nines
);

    logic w_carry;

    // Ripple a +1 carry from the least significant digit upward.
    always_comb begin
        o_val       = i_val;
        o_all_nines = 1'b1;
        w_carry     = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_val[4*d +: 4] != 4'd9) begin
                o_all_nines = 1'b0;
            end
            if (w_carry) begin
                if (i_val[4*d +: 4] == 4'd9) begin
                    o_val[4*d +: 4] = 4'd0;
                end else begin
                    o_val[4*d +: 4] = i_val[4*d +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/time_bcd_converter.sv
// Binary seconds to BCD MM:SS converter using iterative subtraction.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero minute digits
// (all but the minutes ones digit) with BCD_BLANK when the result is published.
//
// state | meaning
// IDLE  | ready for a new seconds value
// MIN   | strip whole minutes (60 s) from the remainder, saturate at all-nines
// TENS  | strip tens of seconds, then latch the ones digit
// DONE  | publish working digits to the output registers, pulse out_valid
module time_bcd_converter
    import time_display_pkg::*;
#(
    parameter int SEC_W      = 12,
    parameter int MIN_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEC_W-1:0]        sec_count,
    output logic                    out_valid,
    output logic [4*MIN_DIGITS-1:0] min_digits,
    output logic [3:0]              sec_tens,
    output logic [3:0]              sec_ones,
    output logic                    overflow
);

    localparam int          MW    = 4*MIN_DIGITS;
    localparam logic [31:0] C_MIN = 32'(SECS_PER_MIN);
    localparam logic [31:0] C_TEN = 32'(SECS_PER_TEN);

    state_t           r_state, w_state_nxt;
    logic [SEC_W-1:0] r_rem, w_rem_nxt;
    logic [MW-1:0]    r_min, w_min_nxt, w_min_inc, w_min_disp;
    logic [3:0]       r_tens, w_tens_nxt, r_ones, w_ones_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             w_all_nines;
    logic             w_ge_min, w_ge_ten;
    logic [31:0]      w_rem_ext;

    // Zero-extended view keeps the compares meaningful even when SEC_W < 6.
    assign w_rem_ext = 32'(r_rem);
    assign w_ge_min  = (w_rem_ext >= C_MIN);
    assign w_ge_ten  = (w_rem_ext >= C_TEN);

    bcd_incr #(.DIGITS(MIN_DIGITS)) u_min_incr (
        .i_val       (r_min),
        .o_val       (w_min_inc),
        .o_all_nines (w_all_nines)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lead;

    // Blank leading zero minute digits from the top; the ones digit always shows.
    always_comb begin
        w_min_disp = r_min;
        w_lead     = 1'b1;
        for (int d = MIN_DIGITS-1; d > 0; d--) begin
            if (w_lead && (r_min[4*d +: 4] == 4'd0)) begin
                w_min_disp[4*d +: 4] = BCD_BLANK;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    assign w_min_disp = r_min;
`endif

    // Next-state and working-register updates.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_min_nxt   = r_min;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_ovf_nxt   = r_ovf;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    w_rem_nxt   = sec_count;
                    w_min_nxt   = '0;
                    w_tens_nxt  = 4'd0;
                    w_ones_nxt  = 4'd0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = MIN;
                end
            end
            MIN: begin
                // The saturating cycle latches max:59; the following cycle hands off to DONE.
                if (r_ovf) begin
                    w_state_nxt = DONE;
                end else if (w_ge_min) begin
                    if (w_all_nines) begin
                        w_tens_nxt = 4'd5;
                        w_ones_nxt = 4'd9;
                        w_ovf_nxt  = 1'b1;
                    end else begin
                        w_rem_nxt = SEC_W'(w_rem_ext - C_MIN);
                        w_min_nxt = w_min_inc;
                    end
                end else begin
                    w_state_nxt = TENS;
                end
            end
            TENS: begin
                if (w_ge_ten) begin
                    w_rem_nxt  = SEC_W'(w_rem_ext - C_TEN);
                    w_tens_nxt = r_tens + 4'd1;
                end else begin
                    w_ones_nxt  = w_rem_ext[3:0];
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, working registers and output registers; outputs move only on the DONE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_min      <= '0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_ovf      <= 1'b0;
            out_valid  <= 1'b0;
            min_digits <= '0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            overflow   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_min     <= w_min_nxt;
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_ovf     <= w_ovf_nxt;
            out_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                min_digits <= w_min_disp;
                sec_tens   <= r_tens;
                sec_ones   <= r_ones;
                overflow   <= r_ovf;
            end
        end
    end

endmodule

// File: tb/tb_time_bcd_converter.sv
// Self-checking bench for time_bcd_converter (SEC_W=16, MIN_DIGITS=2).
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_time_bcd_converter;

    localparam int SW     = 16;
    localparam int MD     = 2;
    localparam int MAXMIN = 10**MD - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [SW-1:0] sec_count = '0;
    logic          in_ready, out_valid, overflow;
    logic [4*MD-1:0] min_digits;
    logic [3:0]    sec_tens, sec_ones;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    int            cyc = 0;
    bit            m_pend = 1'b0;
    int            m_due = 0;
    logic [4*MD-1:0] p_min = '0, d_min = '0;
    logic [3:0]    p_tens = '0, p_ones = '0, d_tens = '0, d_ones = '0;
    logic          p_ovf = 1'b0, d_ovf = 1'b0;

    time_bcd_converter #(.SEC_W(SW), .MIN_DIGITS(MD)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sec_count  (sec_count),
        .out_valid  (out_valid),
        .min_digits (min_digits),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4*MD-1:0] to_disp(input int m);
        logic [4*MD-1:0] r;
        int p;
        r = '0;
        p = m;
        for (int d = 0; d < MD; d++) begin
            r[4*d +: 4] = 4'(p % 10);
            p = p / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int d = MD-1; d > 0; d--) begin
            if (r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'hF;
            else break;
        end
`endif
        return r;
    endfunction

    // Expected result and latency (accept edge to the edge that raises out_valid).
    function automatic void model(input int s, output logic [4*MD-1:0] mn,
                                  output logic [3:0] t, output logic [3:0] o,
                                  output logic ov, output int lat);
        int m;
        m = s / 60;
        if (m > MAXMIN) begin
            mn  = to_disp(MAXMIN);
            t   = 4'd5;
            o   = 4'd9;
            ov  = 1'b1;
            lat = 10**MD + 2;
        end else begin
            mn  = to_disp(m);
            t   = 4'((s % 60) / 10);
            o   = 4'(s % 10);
            ov  = 1'b0;
            lat = m + int'(t) + 3;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Model update on each rising edge (inputs are stable here).
    always @(posedge clk) begin
        bit ready_pre;
        int lat;
        ready_pre = !rst && !(m_pend && cyc < m_due);
        cyc++;
        if (rst) begin
            m_pend = 1'b0;
            d_min = '0; d_tens = '0; d_ones = '0; d_ovf = 1'b0;
        end else begin
            if (m_pend && cyc == m_due) begin
                d_min = p_min; d_tens = p_tens; d_ones = p_ones; d_ovf = p_ovf;
            end
            if (m_pend && cyc > m_due) m_pend = 1'b0;
            if (in_valid && ready_pre) begin
                model(int'(sec_count), p_min, p_tens, p_ones, p_ovf, lat);
                m_pend = 1'b1;
                m_due  = cyc + lat;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_pend && cyc == m_due));
            chk("in_ready",  32'(in_ready),  32'(!rst && !(m_pend && cyc < m_due)));
            chk("min_digits", 32'(min_digits), 32'(d_min));
            chk("sec_tens",  32'(sec_tens), 32'(d_tens));
            chk("sec_ones",  32'(sec_ones), 32'(d_ones));
            chk("overflow",  32'(overflow), 32'(d_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int v);
        in_valid  = 1'b1;
        sec_count = SW'(v);
        step();
        in_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (m_pend && n < 300) begin
            step();
            n++;
        end
        if (m_pend) begin
            total++;
            bad++;
            $display("FAIL wait_done timeout cyc=%0d", cyc);
        end
    endtask

    initial begin
        logic [4*MD-1:0] mn;
        logic [3:0]      t, o;
        logic            ov;
        int              lat;
        logic [4*MD-1:0] e_min61, e_min9;
`ifdef LEADING_ZERO_BLANK_EN
        e_min61 = 8'hF1;
        e_min9  = 8'hF0;
`else
        e_min61 = 8'h01;
        e_min9  = 8'h00;
`endif

        // pin the model with hand-computed values
        model(754, mn, t, o, ov, lat);
        chk("model754_min", 32'(mn), 32'h12);
        chk("model754_lat", 32'(lat), 32'd18);
        model(6000, mn, t, o, ov, lat);
        chk("model6000_ovf", 32'(ov), 32'd1);
        chk("model6000_lat", 32'(lat), 32'd102);
        model(5999, mn, t, o, ov, lat);
        chk("model5999_digits", {20'd0, mn, t, o}, 32'h9959);
        chk("model5999_lat", 32'(lat), 32'd107);
        model(0, mn, t, o, ov, lat);
        chk("model0_lat", 32'(lat), 32'd3);

        // reset
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_digits", {19'd0, overflow, min_digits, sec_tens, sec_ones}, 32'd0);

        // directed conversions
        send(0);    wait_done();
        send(754);  wait_done();
        chk("r754_digits", {20'd0, min_digits, sec_tens, sec_ones}, 32'h1234);
        send(5999); wait_done();
        chk("r5999_ovf", 32'(overflow), 32'd0);
        send(6000); wait_done();
        chk("r6000", {19'd0, overflow, min_digits, sec_tens, sec_ones}, 32'h19959);

        // reset mid-conversion
        send(754);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_digits", {19'd0, overflow, min_digits, sec_tens, sec_ones}, 32'd0);
        repeat (25) step();

        // back-to-back with ignored input while busy
        in_valid  = 1'b1;
        sec_count = SW'(61);
        step();
        sec_count = SW'(9);
        repeat (4) step();
        @(negedge clk);
        chk("b2b_valid61", 32'(out_valid), 32'd1);
        chk("b2b_digits61", {20'd0, min_digits, sec_tens, sec_ones}, {20'd0, e_min61, 8'h01});
        step();
        in_valid = 1'b0;
        wait_done();
        chk("b2b_digits9", {20'd0, min_digits, sec_tens, sec_ones}, {20'd0, e_min9, 8'h09});

        // more patterns and boundaries
        send(59);    wait_done();
`ifdef LEADING_ZERO_BLANK_EN
        chk("blank59", {20'd0, min_digits, sec_tens, sec_ones}, 32'hF059);
`else
        chk("plain59", {20'd0, min_digits, sec_tens, sec_ones}, 32'h0059);
`endif
        send(60);    wait_done();
        send(599);   wait_done();
        send(3600);  wait_done();
        send(65535); wait_done();
        send(5940);  wait_done();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
